// File: rtl/enemy_draw_scheduler.sv
// Walks the enemy formation once per frame tick and hands each live enemy's
// top-left corner to a single shared sprite plotter, one enemy at a time.
module enemy_draw_scheduler #(
    parameter int ROWS      = 3,
    parameter int COLS      = 6,
    parameter int X_SPACING = 32,
    parameter int Y_SPACING = 24,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [8:0]           base_x,
    input  logic [7:0]           base_y,
    input  logic [ROWS*COLS-1:0] alive,
    input  logic                 sprite_done,
    output logic                 sprite_enable,
    output logic [8:0]           sprite_x,
    output logic [7:0]           sprite_y,
    output logic [5:0]           cur_index,
    output logic                 busy,
    output logic                 frame_done,
    output logic [5:0]           drawn_count,
    output logic                 timeout_err
);

    localparam int         N        = ROWS * COLS;
    localparam logic [5:0] LAST_IDX = 6'(N - 1);
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [8:0] X_STEP   = 9'(X_SPACING);
    localparam logic [7:0] Y_STEP   = 8'(Y_SPACING);
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SCAN   = 3'd1;
    localparam logic [2:0] DRAW   = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    logic [2:0]  state;
    // Padded to 64 bits so the 6-bit index selects without width juggling.
    logic [63:0] mask;
    logic [8:0]  base_x_q;
    logic [5:0]  col;
    logic [8:0]  cur_x;
    logic [7:0]  cur_y;
    logic [9:0]  tmo_cnt;
    logic        at_last;
    logic        advance;

    assign at_last = (cur_index == LAST_IDX);
    assign advance = ((state == SCAN) && !mask[cur_index] && !at_last) ||
                     ((state == GAP) && !at_last);

    // NOTE: non-blocking assignments only, so every branch reads pre-edge state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: the latched mask is a plain register and is cleared with everything else.
            state         <= IDLE;
            mask          <= '0;
            base_x_q      <= '0;
            cur_index     <= '0;
            sprite_enable <= 1'b0;
            sprite_x      <= '0;
            sprite_y      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            drawn_count   <= '0;
            timeout_err   <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask        <= 64'(alive);
                        base_x_q    <= base_x;
                        cur_index   <= '0;
                        drawn_count <= '0;
                        busy        <= 1'b1;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (mask[cur_index]) begin
                        sprite_x      <= cur_x;
                        sprite_y      <= cur_y;
                        sprite_enable <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= DRAW;
                    end else if (at_last) begin
                        state <= FINISH;
                    end else begin
                        cur_index <= cur_index + 6'd1;
                    end
                end
                DRAW: begin
                    // Done wins over a timeout landing on the same cycle.
                    if (sprite_enable && sprite_done) begin
                        sprite_enable <= 1'b0;
                        drawn_count   <= drawn_count + 6'd1;
                        state         <= GAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        sprite_enable <= 1'b0;
                        timeout_err   <= 1'b1;
                        state         <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                GAP: begin
                    if (at_last) begin
                        state <= FINISH;
                    end else begin
                        cur_index <= cur_index + 6'd1;
                        state     <= SCAN;
                    end
                end
                FINISH: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Position accumulators: one step per index, row step on column wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col   <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else if ((state == IDLE) && start) begin
            col   <= '0;
            cur_x <= base_x;
            cur_y <= base_y;
        end else if (advance) begin
            if (col == LAST_COL) begin
                col   <= '0;
                cur_x <= base_x_q;
                cur_y <= cur_y + Y_STEP;
            end else begin
                col   <= col + 6'd1;
                cur_x <= cur_x + X_STEP;
            end
        end
    end

endmodule

// File: tb/tb_enemy_draw_scheduler.sv
// Bench for enemy_draw_scheduler: plotter model with per-pulse delays, and a
// frame-level reference computed from the formation geometry.
module tb_enemy_draw_scheduler;

    localparam int ROWS = 3;
    localparam int COLS = 6;
    localparam int N    = ROWS * COLS;
    localparam int XS   = 32;
    localparam int YS   = 24;
    localparam int TMO  = 1023;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [8:0]   base_x = '0;
    logic [7:0]   base_y = '0;
    logic [N-1:0] alive = '0;
    logic         sprite_done = 1'b1;
    logic         sprite_enable;
    logic [8:0]   sprite_x;
    logic [7:0]   sprite_y;
    logic [5:0]   cur_index;
    logic         busy;
    logic         frame_done;
    logic [5:0]   drawn_count;
    logic         timeout_err;

    enemy_draw_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .X_SPACING(XS), .Y_SPACING(YS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_x(base_x), .base_y(base_y),
        .alive(alive), .sprite_done(sprite_done), .sprite_enable(sprite_enable),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .cur_index(cur_index), .busy(busy),
        .frame_done(frame_done), .drawn_count(drawn_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Plotter model: the k-th enable pulse of a frame completes after plot_delay[k]
    // cycles of enable; reports done while idle.
    int plot_delay [64];
    int pulse_no = 0;
    int plot_cnt = 0;
    always @(negedge clk) begin
        if (sprite_enable !== 1'b1) begin
            if (plot_cnt != 0) pulse_no++;
            plot_cnt    = 0;
            sprite_done = 1'b1;
        end else begin
            plot_cnt++;
            sprite_done = (plot_cnt >= plot_delay[pulse_no]);
        end
    end

    // Monitor: records each enable pulse's index/position/length and frame_done pulses.
    bit         mon_prev_en = 1'b0;
    int         en_len = 0;
    int         n_done = 0;
    int         done_cyc = 0;
    int         unstable = 0;
    logic [8:0] hold_x;
    logic [7:0] hold_y;
    logic [5:0] rec_idx [$];
    logic [8:0] rec_x [$];
    logic [7:0] rec_y [$];
    int         rec_len [$];
    always @(negedge clk) begin
        if (sprite_enable === 1'b1 && !mon_prev_en) begin
            rec_idx.push_back(cur_index);
            rec_x.push_back(sprite_x);
            rec_y.push_back(sprite_y);
            hold_x = sprite_x;
            hold_y = sprite_y;
            en_len = 1;
        end else if (sprite_enable === 1'b1) begin
            en_len++;
            if (sprite_x !== hold_x || sprite_y !== hold_y) unstable++;
        end else if (mon_prev_en) begin
            rec_len.push_back(en_len);
        end
        if (frame_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        mon_prev_en = (sprite_enable === 1'b1);
    end

    task automatic set_delays(input int lo, input int hi);
        for (int k = 0; k < 64; k++) plot_delay[k] = $urandom_range(hi, lo);
    endtask

    task automatic run_frame(input string name, input logic [8:0] bx, input logic [7:0] by,
                             input logic [N-1:0] al, input bit poke_start);
        logic [5:0] ei [$];
        logic [8:0] ex [$];
        logic [7:0] ey [$];
        int         el [$];
        int         exp_len;
        int         exp_drawn;
        int         pulse;
        int         done0;
        int         t0;
        int         d;
        exp_len = 1; exp_drawn = 0; pulse = 0;
        for (int i = 0; i < N; i++) begin
            if (al[i]) begin
                d = plot_delay[pulse];
                ei.push_back(6'(i));
                ex.push_back(9'(int'(bx) + (i % COLS) * XS));
                ey.push_back(8'(int'(by) + (i / COLS) * YS));
                el.push_back(d > TMO ? TMO : d);
                if (d > TMO) model_err = 1'b1;
                else exp_drawn++;
                exp_len += (d > TMO ? TMO : d) + 2;
                pulse++;
            end else begin
                exp_len += 1;
            end
        end

        rec_idx.delete(); rec_x.delete(); rec_y.delete(); rec_len.delete();
        unstable = 0;
        pulse_no = 0;
        done0    = n_done;
        @(negedge clk);
        base_x = bx; base_y = by; alive = al; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        base_x = 9'($urandom);
        base_y = 8'($urandom);
        alive  = N'($urandom);
        t0     = cyc;
        check({name, " busy after start"}, busy, 1);
        if (poke_start) begin
            repeat (100) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int c = 0; c < exp_len + 20 && n_done == done0; c++) @(negedge clk);
        repeat (5) @(negedge clk);

        check({name, " frame_done count"}, n_done - done0, 1);
        check({name, " frame length"}, done_cyc - t0, exp_len);
        check({name, " enable pulses"}, rec_idx.size(), ei.size());
        for (int k = 0; k < ei.size() && k < rec_idx.size() && k < rec_len.size(); k++) begin
            check($sformatf("%s idx[%0d]", name, k), rec_idx[k], ei[k]);
            check($sformatf("%s x[%0d]", name, k), rec_x[k], ex[k]);
            check($sformatf("%s y[%0d]", name, k), rec_y[k], ey[k]);
            check($sformatf("%s len[%0d]", name, k), rec_len[k], el[k]);
        end
        check({name, " xy stable"}, unstable, 0);
        check({name, " drawn_count"}, drawn_count, exp_drawn);
        check({name, " busy after"}, busy, 0);
        check({name, " enable after"}, sprite_enable, 0);
        check({name, " timeout_err"}, timeout_err, model_err);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int done0;
        int c;
        logic [N-1:0] al;

        // Reset state.
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst sprite_enable", sprite_enable, 0);
        check("rst sprite_x", sprite_x, 0);
        check("rst sprite_y", sprite_y, 0);
        check("rst cur_index", cur_index, 0);
        check("rst busy", busy, 0);
        check("rst frame_done", frame_done, 0);
        check("rst drawn_count", drawn_count, 0);
        check("rst timeout_err", timeout_err, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Whole formation, slow plotter, extra start pulse mid-frame.
        for (int k = 0; k < 64; k++) plot_delay[k] = 560;
        run_frame("all", 9'd20, 8'd10, 18'h3FFFF, 1'b1);
        check("all enemy7 x", rec_x.size() > 7 ? rec_x[7] : 9'h1FF, 52);
        check("all enemy7 y", rec_y.size() > 7 ? rec_y[7] : 8'hFF, 34);

        // Sparse mask: first and last enemy only.
        set_delays(1, 40);
        run_frame("sparse", 9'd20, 8'd10, 18'h20001, 1'b0);
        check("sparse last x", rec_x.size() > 1 ? rec_x[1] : 9'h1FF, 180);
        check("sparse last y", rec_y.size() > 1 ? rec_y[1] : 8'hFF, 58);

        // Empty mask.
        run_frame("empty", 9'($urandom), 8'($urandom), '0, 1'b0);

        // Plotter hangs on the fourth live enemy (index 3).
        set_delays(1, 30);
        plot_delay[3] = 5000;
        run_frame("timeout", 9'd20, 8'd10, 18'h3FFFF, 1'b0);

        // Clean frame afterwards: error stays sticky.
        set_delays(1, 30);
        run_frame("sticky", 9'($urandom), 8'($urandom), N'($urandom), 1'b0);

        // Reset while drawing enemy 5.
        for (int k = 0; k < 64; k++) plot_delay[k] = 50;
        pulse_no = 0;
        @(negedge clk);
        alive = 18'h3FFFF; base_x = 9'd20; base_y = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!(sprite_enable === 1'b1 && cur_index == 6'd5) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("middraw reached idx5", c < 2000, 1);
        done0  = n_done;
        resetn = 1'b0;
        @(negedge clk);
        check("middraw sprite_enable", sprite_enable, 0);
        check("middraw busy", busy, 0);
        check("middraw frame_done", frame_done, 0);
        check("middraw timeout_err", timeout_err, 0);
        check("middraw drawn_count", drawn_count, 0);
        check("middraw cur_index", cur_index, 0);
        repeat (2) @(negedge clk);
        resetn    = 1'b1;
        model_err = 1'b0;
        repeat (30) @(negedge clk);
        check("middraw no frame_done", n_done - done0, 0);
        check("middraw idle busy", busy, 0);

        // Done arriving on the same cycle as the timeout counts as done.
        for (int k = 0; k < 64; k++) plot_delay[k] = TMO;
        al = '0;
        al[$urandom_range(N - 1, 0)] = 1'b1;
        al[N-1] = 1'b1;
        run_frame("edge_tmo", 9'($urandom), 8'($urandom), al, 1'b0);

        // Start coinciding with reset: reset wins.
        @(negedge clk);
        resetn = 1'b0; start = 1'b1; alive = 18'h3FFFF;
        @(negedge clk);
        resetn = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst+start busy", busy, 0);
        check("rst+start enable", sprite_enable, 0);

        // Randomized frames with wrapping bases.
        for (int f = 0; f < 6; f++) begin
            set_delays(1, 25);
            if (f == 3) plot_delay[$urandom_range(4, 0)] = 1500;
            run_frame($sformatf("rand%0d", f), 9'($urandom), 8'($urandom), N'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/enemy_draw_scheduler.md
Name: enemy_draw_scheduler

Overview:
- Frame-level sequencer that walks the enemy formation grid and draws each live enemy through one shared sprite plotter.
- The plotter takes enable plus an initial x/y and returns done.
- Sits between the game-logic block (formation position, alive mask, frame tick) and the single enemy sprite plotter whose x/y/colour drive the VGA adapter.
- Only one enemy is plotted at a time; dead enemies are skipped without touching the plotter.

Parameters:
- ROWS, 3, formation rows.
- COLS, 6, formation columns; ROWS*COLS <= 63.
- X_SPACING, 32, horizontal pixel pitch between columns.
- Y_SPACING, 24, vertical pixel pitch between rows.
- TIMEOUT, 1023, maximum cycles to wait for sprite_done per enemy; 10-bit counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle frame tick; request to draw the whole formation.
- base_x  in  9  formation top-left x; sampled on accepted start.
- base_y  in  8  formation top-left y; sampled on accepted start.
- alive  in  ROWS*COLS  bit i=1 means enemy i is alive; i = row*COLS+col; sampled on accepted start.
- sprite_done  in  1  done from the sprite plotter.
- sprite_enable  out  1  plot request to the sprite plotter.
- sprite_x  out  9  initial x for the current enemy.
- sprite_y  out  8  initial y for the current enemy.
- cur_index  out  6  index of the enemy being scanned or drawn.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse when the scan completes.
- drawn_count  out  6  live enemies drawn in the last or current frame.
- timeout_err  out  1  sticky; set when any draw times out.

Behaviour:
- All outputs are registered. On resetn=0 at a clk edge:
  - state=IDLE; all outputs 0; timeout_err cleared.
  - Latched mask and base are cleared.
  - Reset mid-draw drops sprite_enable on the next edge. No frame_done is issued.
- States: IDLE, SCAN, DRAW, GAP, FINISH.
- IDLE:
  - On start=1: latch alive, base_x, base_y; idx=0; row=col=0; drawn_count=0; busy=1; go to SCAN.
  - start is ignored in every other state. There is no queuing.
- Position tracking uses accumulators, not multipliers:
  - cur_x = base_x + col*X_SPACING, mod 2^9.
  - cur_y = base_y + row*Y_SPACING, mod 2^8.
  - Wrap-around is silent truncation.
  - Advancing col adds X_SPACING. When col wraps from COLS-1 to 0: reset cur_x to base_x, add Y_SPACING to cur_y, row++.
- SCAN, one index per cycle:
  - If mask[idx]=1: load sprite_x=cur_x, sprite_y=cur_y, sprite_enable=1, clear timeout counter, go to DRAW.
  - Else if idx = ROWS*COLS-1: go to FINISH.
  - Else advance idx and position; stay in SCAN.
- DRAW:
  - sprite_enable held 1; sprite_x and sprite_y held stable.
  - sprite_done is sampled only while sprite_enable=1, because the plotter reports done=1 while its enable is low.
  - On sprite_done=1: sprite_enable<=0, drawn_count++, go to GAP.
  - Else if the counter reaches TIMEOUT: sprite_enable<=0, timeout_err<=1, go to GAP. drawn_count is not incremented.
- GAP:
  - Exactly one cycle with sprite_enable=0, so the plotter returns to its wait state and does not restart.
  - If idx = ROWS*COLS-1: go to FINISH.
  - Else advance idx and position; go to SCAN.
- FINISH:
  - frame_done=1 for one cycle; busy<=0; go to IDLE.
  - drawn_count holds until the next accepted start.
- Latency:
  - start → first sprite_enable rise is 2 cycles when enemy 0 is alive.
  - Each dead enemy costs 1 cycle.
  - Each live enemy costs its plot time + 2 cycles (DRAW exit + GAP).
- Boundary cases:
  - alive all-zero → frame_done exactly ROWS*COLS+1 cycles after start, with no sprite_enable.
  - start coinciding with a reset edge → reset wins.
  - sprite_done=1 in the same cycle as the timeout → treated as done; no error.

Test Plan:
- Reset behaviour: hold resetn=0 for 3 cycles → all outputs 0; state IDLE.
- All alive, plotter model returns done 560 cycles after enable:
  - start with base (20,10), alive=18'h3FFFF → 18 enable pulses.
  - Enemy 7 is drawn at sprite_x=52, sprite_y=34.
  - frame_done once; drawn_count=18; busy low after.
- Sparse mask:
  - alive=18'h20001 → only idx 0 at (20,10) and idx 17 at (180,58) are drawn; drawn_count=2.
  - No enable while scanning idx 1–16.
- Empty mask: alive=0 → no sprite_enable; frame_done 19 cycles after start; drawn_count=0.
- Timeout:
  - Plotter never asserts done for idx 3 → enable drops after 1023 cycles; timeout_err=1.
  - Remaining enemies are still drawn; drawn_count=17.
  - A second start with no timeouts leaves timeout_err=1.
- Reset mid-draw / start while busy:
  - resetn=0 during DRAW of idx 5 → next edge sprite_enable=0 and busy=0; no frame_done.
  - A start pulse during DRAW is ignored, verified by exactly one frame_done.
